gfx_axil_regs: RTL and testbench
================================

# gfx_axil_regs

AXI4-Lite slave register file for the graphics engine; the responder side of the host's control-register writes at 0x4400_0000. It decodes register offsets (not the full address), holds configuration (enable, framebuffer base, command word) and issues a command to the engine over a valid/ready handshake. It also reports engine status back to the host through the read channel.

## Interface
- ADDR_W, 6: AXI address bits decoded; upper bits ignored.
- FB_RST, 32'h1000_0000: reset value of FB_BASE.
- aclk  in  1  sole clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data.
- gfx_enable  out  1  mirrors CTRL[0].
- fb_base  out  32  FB_BASE register.
- cmd_valid/cmd_ready  out/in  1/1  command handshake to engine.
- cmd_op  out  8  opcode; stable while cmd_valid.
- eng_busy  in  1  engine busy level.
- eng_done  in  1  one-cycle completion pulse.
- irq  out  1  level interrupt (see Configuration).

## Operation
- Map (offset = addr[4:2]*4): 0x00 CTRL RW bit0 enable; 0x04 STATUS RO {done_sticky[2], eng_busy[1], cmd_pending[0]}; 0x08 IRQ W1C bit0 done_irq; 0x0C CMD bits[7:0] opcode RW, bit8 GO (write-only, reads 0), bit9 irq_en RW; 0x10 FB_BASE RW. Offsets 0x14–0x3F: reads 0 with SLVERR; writes dropped with SLVERR.
- WSTRB honoured per byte on RW fields; GO acts only if wstrb[1]=1.
- GO=1 with cmd_pending=0: latch opcode, set cmd_pending, clear done_sticky. GO=1 with cmd_pending=1: entire CMD write dropped, bresp=SLVERR.
- cmd_valid = cmd_pending; clears on the cycle cmd_valid&cmd_ready.
- eng_done sets done_sticky; if irq_en also sets done_irq.
- Write FSM: W_IDLE -> (AW and/or W latched) W_WAIT -> both held: commit, W_RESP (bvalid=1) -> bready: W_IDLE. AW and W may arrive in either order or together.
- Read FSM: R_IDLE (arready=1) -> arvalid: R_DATA (rvalid=1, rdata registered) -> rready: R_IDLE.
- Reset values: all ready/valid outputs 0 then awready=wready=arready=1 in idle; bresp=rresp=0; rdata=0; CTRL=0; CMD=0; FB_BASE=FB_RST; cmd_valid=0; irq=0; all sticky bits 0.

## Timing
- Write: bvalid asserts the cycle after the later of AW/W handshake; register update on that same edge.
- awready deasserts once AW latched until bvalid&bready; same for wready with W.
- Read: rvalid the cycle after ar handshake; one outstanding read, one outstanding write.
- Simultaneous read and write to same register: read returns pre-write value.
- eng_done same cycle as W1C clear of done_irq: set wins.
- GO write same cycle as cmd_ready: pending command retires, new write sees pending=1 -> SLVERR.
- areset mid-transaction: all channels return to idle immediately; in-flight transfers discarded, no bvalid/rvalid.

## Configuration
- GFX_REGS_IRQ_EN defined: IRQ register, irq_en bit and irq = done_irq implemented.
- Undefined: irq tied 0; 0x08 reads 0 with OKAY, writes ignored with OKAY; CMD bit9 reads 0.

## Test plan
- Reset, read 0x4400_0010 -> rdata 0x1000_0000, OKAY; read 0x00 -> 0.
- W before AW: write 0x0C data 0x205 (op 5, irq_en) then 0x305 -> cmd_valid=1, cmd_op=5; cmd_ready pulse -> cmd_valid=0 next cycle.
- GO while pending (cmd_ready held 0): second write 0x105 -> bresp=SLVERR, opcode unchanged.
- eng_done pulse with irq_en -> STATUS=0x4, irq=1; write 0x08 data 1 -> irq=0 (IRQ_EN build).
- Write 0x10 data 0xAABBCCDD wstrb 0x3 -> fb_base 0x1000_CCDD; write offset 0x20 -> SLVERR.
- Assert areset while bvalid pending -> bvalid=0 immediately, CTRL=0, fb_base=0x1000_0000.

Source files
------------

// File: rtl/gfx_axil_regs_if.sv
// AXI4-Lite bus bundle between the host interconnect and the graphics register file.
interface gfx_axil_regs_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/gfx_axil_regs.sv
// AXI4-Lite control registers and command issue for the graphics engine.
// Define GFX_REGS_IRQ_EN to build the IRQ register, the CMD irq_en bit and the irq output.
module gfx_axil_regs #(
   parameter int          ADDR_W = 6,
   parameter logic [31:0] FB_RST = 32'h1000_0000
) (
   input  logic           aclk,
   input  logic           areset,
   gfx_axil_regs_if.slave s_axi,
   output logic           gfx_enable,
   output logic [31:0]    fb_base,
   output logic           cmd_valid,
   input  logic           cmd_ready,
   output logic [7:0]     cmd_op,
   input  logic           eng_busy,
   input  logic           eng_done,
   output logic           irq
);
   localparam int         IDX_W       = ADDR_W - 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

   wstate_t           r_wstate;
   rstate_t           r_rstate;
   logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
   logic [1:0]        r_bresp, r_rresp;
   logic [31:0]       r_rdata;
   logic              r_aw_have, r_w_have;
   logic [ADDR_W-1:0] r_awaddr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;

   logic              r_enable;
   logic [31:0]       r_fb_base;
   logic [7:0]        r_opcode;
   logic [7:0]        r_cmd_op;
   logic              r_cmd_pending;
   logic              r_done_sticky;
   logic              w_irq_en;
   logic              w_done_irq;

   logic              w_aw_hs, w_w_hs, w_ar_hs, w_cmd_hs, w_commit;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [31:0]       w_wr_data;
   logic [3:0]        w_wr_strb;
   logic              w_wr_valid, w_go, w_cmd_drop, w_go_ok;
   logic              w_sel_ctrl, w_sel_cmd, w_sel_fb;
   logic              w_rd_valid;
   logic [31:0]       w_rd_data;
   logic [1:0]        w_rd_resp;

   assign w_aw_hs  = s_axi.awvalid & r_awready;
   assign w_w_hs   = s_axi.wvalid & r_wready;
   assign w_ar_hs  = s_axi.arvalid & r_arready;
   assign w_cmd_hs = r_cmd_pending & cmd_ready;
   assign w_commit = (r_wstate != W_RESP) & (r_aw_have | w_aw_hs) & (r_w_have | w_w_hs);

   // A half already latched takes priority over the live bus value.
   assign w_wr_addr  = r_aw_have ? r_awaddr : s_axi.awaddr;
   assign w_wr_data  = r_w_have  ? r_wdata  : s_axi.wdata;
   assign w_wr_strb  = r_w_have  ? r_wstrb  : s_axi.wstrb;
   assign w_wr_valid = w_wr_addr[ADDR_W-1:2] < IDX_W'(5);
   assign w_sel_ctrl = w_commit & w_wr_valid & (w_wr_addr[4:2] == 3'd0);
   assign w_sel_cmd  = w_commit & w_wr_valid & (w_wr_addr[4:2] == 3'd3);
   assign w_sel_fb   = w_commit & w_wr_valid & (w_wr_addr[4:2] == 3'd4);
   assign w_go       = w_wr_strb[1] & w_wr_data[8];
   assign w_cmd_drop = w_sel_cmd & w_go & r_cmd_pending;
   assign w_go_ok    = w_sel_cmd & w_go & ~r_cmd_pending;

   assign w_rd_valid = s_axi.araddr[ADDR_W-1:2] < IDX_W'(5);

   always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
      w_rd_data = '0;
      w_rd_resp = RESP_OKAY;
      if (!w_rd_valid) begin
         w_rd_resp = RESP_SLVERR;
      end else begin
         case (s_axi.araddr[4:2])
            3'd0:    w_rd_data = {31'b0, r_enable};
            3'd1:    w_rd_data = {29'b0, r_done_sticky, eng_busy, r_cmd_pending};
            3'd2:    w_rd_data = {31'b0, w_done_irq};
            3'd3:    w_rd_data = {22'b0, w_irq_en, 1'b0, r_opcode};
            3'd4:    w_rd_data = r_fb_base;
            default: w_rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (areset) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_aw_have <= 1'b0;
         r_w_have  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         case (r_wstate)
            W_IDLE, W_WAIT: begin
               if (w_aw_hs) begin
                  r_awaddr  <= s_axi.awaddr;
                  r_aw_have <= 1'b1;
                  r_awready <= 1'b0;
               end else if (!r_aw_have) begin
                  r_awready <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wdata  <= s_axi.wdata;
                  r_wstrb  <= s_axi.wstrb;
                  r_w_have <= 1'b1;
                  r_wready <= 1'b0;
               end else if (!r_w_have) begin
                  r_wready <= 1'b1;
               end
               if (w_commit) begin
                  r_wstate <= W_RESP;
                  r_bvalid <= 1'b1;
                  r_bresp  <= (!w_wr_valid || w_cmd_drop) ? RESP_SLVERR : RESP_OKAY;
               end else if (w_aw_hs || w_w_hs) begin
                  r_wstate <= W_WAIT;
               end
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  r_wstate  <= W_IDLE;
                  r_bvalid  <= 1'b0;
                  r_aw_have <= 1'b0;
                  r_w_have  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rstate  <= R_DATA;
                  r_rdata   <= w_rd_data;
                  r_rresp   <= w_rd_resp;
                  r_rvalid  <= 1'b1;
                  r_arready <= 1'b0;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  r_rstate  <= R_IDLE;
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_enable      <= 1'b0;
         r_fb_base     <= FB_RST;
         r_opcode      <= '0;
         r_cmd_op      <= '0;
         r_cmd_pending <= 1'b0;
         r_done_sticky <= 1'b0;
      end else begin
         if (w_sel_ctrl && w_wr_strb[0]) r_enable <= w_wr_data[0];
         for (int b = 0; b < 4; b++) begin
            if (w_sel_fb && w_wr_strb[b]) r_fb_base[8*b +: 8] <= w_wr_data[8*b +: 8];
         end
         if (w_sel_cmd && !w_cmd_drop && w_wr_strb[0]) r_opcode <= w_wr_data[7:0];
         if (w_cmd_hs) r_cmd_pending <= 1'b0;
         // The issued opcode is captured separately so cmd_op holds still while pending.
         if (w_go_ok) begin
            r_cmd_op      <= w_wr_strb[0] ? w_wr_data[7:0] : r_opcode;
            r_cmd_pending <= 1'b1;
            r_done_sticky <= 1'b0;
         end
         if (eng_done) r_done_sticky <= 1'b1;
      end
   end

`ifdef GFX_REGS_IRQ_EN
   logic r_irq_en;
   logic r_done_irq;
   logic w_sel_irq;

   assign w_sel_irq = w_commit & w_wr_valid & (w_wr_addr[4:2] == 3'd2);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_irq_en   <= 1'b0;
         r_done_irq <= 1'b0;
      end else begin
         if (w_sel_cmd && !w_cmd_drop && w_wr_strb[1]) r_irq_en <= w_wr_data[9];
         if (w_sel_irq && w_wr_strb[0] && w_wr_data[0]) r_done_irq <= 1'b0;
         if (eng_done && r_irq_en) r_done_irq <= 1'b1;
      end
   end

   assign w_irq_en   = r_irq_en;
   assign w_done_irq = r_done_irq;
`else
   assign w_irq_en   = 1'b0;
   assign w_done_irq = 1'b0;
`endif

   assign s_axi.awready = r_awready;
   assign s_axi.wready  = r_wready;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = r_arready;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
   assign gfx_enable    = r_enable;
   assign fb_base       = r_fb_base;
   assign cmd_valid     = r_cmd_pending;
   assign cmd_op        = r_cmd_op;
   assign irq           = w_done_irq;
endmodule

// File: tb/tb_gfx_axil_regs.sv
// Directed bench for gfx_axil_regs; AXI responses are checked by a scoreboard monitor.
module tb_gfx_axil_regs;
   localparam int         ADDR_W = 6;
   localparam int         TMO    = 50;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
`ifdef GFX_REGS_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        areset;
   logic        gfx_enable;
   logic [31:0] fb_base;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_op;
   logic        eng_busy;
   logic        eng_done;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]  wq[$];
   string       wq_name[$];
   logic [33:0] rq[$];
   string       rq_name[$];
   logic [33:0] r_exp;
   string       nm;

   gfx_axil_regs_if #(.ADDR_W(ADDR_W)) axi ();

   gfx_axil_regs #(.ADDR_W(ADDR_W), .FB_RST(32'h1000_0000)) dut (
      .aclk       (aclk),
      .areset     (areset),
      .s_axi      (axi),
      .gfx_enable (gfx_enable),
      .fb_base    (fb_base),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .eng_busy   (eng_busy),
      .eng_done   (eng_done),
      .irq        (irq)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops an expected response whenever a B or R beat completes.
   always @(negedge aclk) begin
      if (!areset) begin
         if (axi.bvalid && axi.bready) begin
            if (wq.size() == 0) begin
               check("b_unexpected", 32'd1, 32'd0);
            end else begin
               nm = wq_name.pop_front();
               check({nm, "_bresp"}, {30'b0, axi.bresp}, {30'b0, wq.pop_front()});
            end
         end
         if (axi.rvalid && axi.rready) begin
            if (rq.size() == 0) begin
               check("r_unexpected", 32'd1, 32'd0);
            end else begin
               nm    = rq_name.pop_front();
               r_exp = rq.pop_front();
               check({nm, "_rdata"}, axi.rdata, r_exp[31:0]);
               check({nm, "_rresp"}, {30'b0, axi.rresp}, {30'b0, r_exp[33:32]});
            end
         end
      end
   end

   task automatic send_aw(input logic [31:0] addr);
      axi.awaddr  = addr[ADDR_W-1:0];
      axi.awvalid = 1'b1;
      for (int i = 0; i < TMO; i++) begin
         @(negedge aclk);
         if (axi.awready) begin
            @(posedge aclk); #1;
            axi.awvalid = 1'b0;
            return;
         end
      end
      check("aw_timeout", 32'd1, 32'd0);
      axi.awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
      axi.wdata  = data;
      axi.wstrb  = strb;
      axi.wvalid = 1'b1;
      for (int i = 0; i < TMO; i++) begin
         @(negedge aclk);
         if (axi.wready) begin
            @(posedge aclk); #1;
            axi.wvalid = 1'b0;
            return;
         end
      end
      check("w_timeout", 32'd1, 32'd0);
      axi.wvalid = 1'b0;
   endtask

   // order: 0 = AW and W together, 1 = W first, 2 = AW first
   task automatic axi_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int order, input logic [1:0] exp_resp,
                            input bit wait_b);
      wq.push_back(exp_resp);
      wq_name.push_back(name);
      if (order == 1) begin
         send_w(data, strb);
         send_aw(addr);
      end else if (order == 2) begin
         send_aw(addr);
         send_w(data, strb);
      end else begin
         fork
            send_aw(addr);
            send_w(data, strb);
         join
      end
      if (wait_b) begin
         for (int i = 0; i < TMO; i++) begin
            @(negedge aclk);
            if (axi.bvalid && axi.bready) begin
               @(posedge aclk); #1;
               return;
            end
         end
         check({name, "_b_timeout"}, 32'd1, 32'd0);
      end
   endtask

   task automatic axi_read(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      rq.push_back({exp_resp, exp_data});
      rq_name.push_back(name);
      axi.araddr  = addr[ADDR_W-1:0];
      axi.arvalid = 1'b1;
      for (int i = 0; i < TMO; i++) begin
         @(negedge aclk);
         if (axi.arready) break;
         if (i == TMO - 1) check({name, "_ar_timeout"}, 32'd1, 32'd0);
      end
      @(posedge aclk); #1;
      axi.arvalid = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         @(negedge aclk);
         if (axi.rvalid && axi.rready) begin
            @(posedge aclk); #1;
            return;
         end
      end
      check({name, "_r_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic pulse_cmd_ready();
      @(posedge aclk); #1;
      cmd_ready = 1'b1;
      @(posedge aclk); #1;
      cmd_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      areset      = 1'b1;
      cmd_ready   = 1'b0;
      eng_busy    = 1'b0;
      eng_done    = 1'b0;
      axi.awaddr  = '0;
      axi.awvalid = 1'b0;
      axi.wdata   = '0;
      axi.wstrb   = '0;
      axi.wvalid  = 1'b0;
      axi.bready  = 1'b1;
      axi.araddr  = '0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b1;
      #1;
      check("rst_awready", {31'b0, axi.awready}, 32'd0);
      check("rst_arready", {31'b0, axi.arready}, 32'd0);
      check("rst_bvalid",  {31'b0, axi.bvalid},  32'd0);
      check("rst_rvalid",  {31'b0, axi.rvalid},  32'd0);
      check("rst_rdata",   axi.rdata,            32'd0);
      check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
      check("rst_irq",     {31'b0, irq},         32'd0);
      check("rst_enable",  {31'b0, gfx_enable},  32'd0);
      check("rst_fb_base", fb_base,              32'h1000_0000);
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      check("idle_awready", {31'b0, axi.awready}, 32'd1);
      check("idle_wready",  {31'b0, axi.wready},  32'd1);
      check("idle_arready", {31'b0, axi.arready}, 32'd1);

      axi_read("rd_fb_rst", 32'h4400_0010, 32'h1000_0000, OKAY);
      axi_read("rd_ctrl_rst", 32'h4400_0000, 32'h0, OKAY);

      axi_write("wr_cmd_op5", 32'h4400_000C, 32'h205, 4'hF, 1, OKAY, 1'b1);
      check("no_go_cmd_valid", {31'b0, cmd_valid}, 32'd0);
      axi_read("rd_cmd_op5", 32'h4400_000C, IRQ_BUILD ? 32'h205 : 32'h005, OKAY);
      axi_write("wr_cmd_go", 32'h4400_000C, 32'h305, 4'hF, 1, OKAY, 1'b1);
      check("go_cmd_valid", {31'b0, cmd_valid}, 32'd1);
      check("go_cmd_op", {24'b0, cmd_op}, 32'h5);
      axi_read("rd_status_pend", 32'h4400_0004, 32'h1, OKAY);

      axi_write("wr_go_busy", 32'h4400_000C, 32'h1A7, 4'hF, 0, SLVERR, 1'b1);
      axi_read("rd_cmd_kept", 32'h4400_000C, IRQ_BUILD ? 32'h205 : 32'h005, OKAY);
      check("busy_cmd_op", {24'b0, cmd_op}, 32'h5);
      check("busy_cmd_valid", {31'b0, cmd_valid}, 32'd1);
      pulse_cmd_ready();
      check("retire_cmd_valid", {31'b0, cmd_valid}, 32'd0);

      @(posedge aclk); #1 eng_done = 1'b1;
      @(posedge aclk); #1 eng_done = 1'b0;
      check("done_irq", {31'b0, irq}, IRQ_BUILD ? 32'd1 : 32'd0);
      axi_read("rd_status_done", 32'h4400_0004, 32'h4, OKAY);
      axi_read("rd_irq_reg", 32'h4400_0008, IRQ_BUILD ? 32'h1 : 32'h0, OKAY);
      axi_write("wr_irq_w1c", 32'h4400_0008, 32'h1, 4'hF, 0, OKAY, 1'b1);
      check("w1c_irq", {31'b0, irq}, 32'd0);
      eng_busy = 1'b1;
      axi_read("rd_status_busy", 32'h4400_0004, 32'h6, OKAY);
      eng_busy = 1'b0;

      axi_write("wr_fb_strb", 32'h4400_0010, 32'hAABB_CCDD, 4'h3, 2, OKAY, 1'b1);
      check("fb_strb", fb_base, 32'h1000_CCDD);
      axi_read("rd_fb_strb", 32'h4400_0010, 32'h1000_CCDD, OKAY);
      axi_write("wr_bad_off", 32'h4400_0020, 32'hFFFF_FFFF, 4'hF, 0, SLVERR, 1'b1);
      check("bad_off_fb", fb_base, 32'h1000_CCDD);
      axi_read("rd_bad_20", 32'h4400_0020, 32'h0, SLVERR);
      axi_read("rd_bad_14", 32'h4400_0014, 32'h0, SLVERR);
      axi_read("rd_bad_3c", 32'h4400_003C, 32'h0, SLVERR);
      axi_read("rd_ctrl_alias", 32'h4400_0000, 32'h0, OKAY);

      axi_write("wr_ctrl_en", 32'h4400_0000, 32'h1, 4'h1, 0, OKAY, 1'b1);
      check("ctrl_enable", {31'b0, gfx_enable}, 32'd1);
      axi_write("wr_ctrl_nostrb", 32'h4400_0000, 32'h0, 4'h0, 0, OKAY, 1'b1);
      check("ctrl_nostrb", {31'b0, gfx_enable}, 32'd1);
      fork
         axi_write("wr_ctrl_clr", 32'h4400_0000, 32'h0, 4'hF, 0, OKAY, 1'b1);
         axi_read("rd_ctrl_pre", 32'h4400_0000, 32'h1, OKAY);
      join
      check("ctrl_cleared", {31'b0, gfx_enable}, 32'd0);

      axi_write("wr_go_nostrb", 32'h4400_000C, 32'h1FF, 4'h1, 0, OKAY, 1'b1);
      check("go_nostrb_valid", {31'b0, cmd_valid}, 32'd0);
      axi_read("rd_cmd_ff", 32'h4400_000C, IRQ_BUILD ? 32'h2FF : 32'h0FF, OKAY);
      axi_write("wr_go_42", 32'h4400_000C, 32'h342, 4'h3, 0, OKAY, 1'b1);
      check("go42_valid", {31'b0, cmd_valid}, 32'd1);
      check("go42_op", {24'b0, cmd_op}, 32'h42);
      axi_read("rd_status_go", 32'h4400_0004, 32'h1, OKAY);
      pulse_cmd_ready();
      check("go42_retire", {31'b0, cmd_valid}, 32'd0);

      axi.bready = 1'b0;
      axi_write("wr_ctrl_rst", 32'h4400_0000, 32'h1, 4'h1, 0, OKAY, 1'b0);
      check("pre_rst_bvalid", {31'b0, axi.bvalid}, 32'd1);
      check("pre_rst_enable", {31'b0, gfx_enable}, 32'd1);
      areset = 1'b1;
      #1;
      check("mid_rst_bvalid", {31'b0, axi.bvalid}, 32'd0);
      check("mid_rst_enable", {31'b0, gfx_enable}, 32'd0);
      check("mid_rst_fb", fb_base, 32'h1000_0000);
      wq.delete();
      wq_name.delete();
      axi.bready = 1'b1;
      @(posedge aclk); #1 areset = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      axi_read("rd_ctrl_post", 32'h4400_0000, 32'h0, OKAY);
      axi_read("rd_fb_post", 32'h4400_0010, 32'h1000_0000, OKAY);

      repeat (3) @(posedge aclk);
      check("wq_drained", wq.size(), 32'd0);
      check("rq_drained", rq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
